// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lif_pkg
// Description : Shared types, reset-mode constants and saturating arithmetic
//               for the LIF neuron array.
// Revision    : 1.0 - initial release
// ============================================================================
package lif_pkg;

    localparam logic RESET_SUBTRACT = 1'b0;
    localparam logic RESET_TO_VALUE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Operands arrive sign-extended to 32 bits; result is clamped to w-bit signed range.
    function automatic logic signed [31:0] sat_clamp(input logic signed [32:0] s,
                                                      input int unsigned     w);
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -hi - 33'sd1;
        if (s > hi)
            return hi[31:0];
        else if (s < lo)
            return lo[31:0];
        else
            return s[31:0];
    endfunction

    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                    input logic signed [31:0] b,
                                                    input int unsigned        w);
        return sat_clamp({a[31], a} + {b[31], b}, w);
    endfunction

    function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                    input logic signed [31:0] b,
                                                    input int unsigned        w);
        return sat_clamp({a[31], a} - {b[31], b}, w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lif_neuron_array_if.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron_array_if
// Description : Weight-event input and spike output handshakes of the array.
// Revision    : 1.0 - initial release
// ============================================================================
interface lif_neuron_array_if #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 16
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [ID_W-1:0]          in_id;
    logic signed [DATA_W-1:0] in_weight;
    logic                     spike_valid;
    logic                     spike_ready;
    logic [ID_W-1:0]          spike_id;

    modport master (
        output in_valid, in_id, in_weight, spike_ready,
        input  in_ready, spike_valid, spike_id
    );

    modport slave (
        input  in_valid, in_id, in_weight, spike_ready,
        output in_ready, spike_valid, spike_id
    );
endinterface
`default_nettype wire

// File: rtl/lif_neuron_update.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron_update
// Description : Combinational leak / integrate / fire / reset step for one
//               neuron, shared across the update sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron_update
    import lif_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REFRAC_W = 4
) (
    input  logic signed [DATA_W-1:0] v,
    input  logic signed [DATA_W-1:0] a,
    input  logic [REFRAC_W-1:0]      r,
    input  logic signed [DATA_W-1:0] v_threshold,
    input  logic signed [DATA_W-1:0] v_reset,
    input  logic                     reset_mode,
    input  logic [3:0]               leak_shift,
    input  logic [REFRAC_W-1:0]      refrac,
    output logic signed [DATA_W-1:0] v_next,
    output logic [REFRAC_W-1:0]      r_next,
    output logic                     fire
);

    logic signed [DATA_W-1:0] w_leak;
    logic signed [DATA_W-1:0] w_sum;

    always_comb begin
        // V - (V>>>s) keeps the sign of V and never exceeds |V|, so no clamp needed.
        w_leak = (leak_shift == 4'd0) ? v : v - (v >>> leak_shift);
        w_sum  = DATA_W'(sat_add(32'(w_leak), 32'(a), DATA_W));
        fire   = 1'b0;
        v_next = w_sum;
        r_next = r;
        if (r != '0) begin
            r_next = r - 1'b1;
            v_next = v_reset;
        end else if (w_sum >= v_threshold) begin
            fire   = 1'b1;
            r_next = refrac;
            v_next = (reset_mode == RESET_TO_VALUE) ? v_reset
                   : DATA_W'(sat_sub(32'(w_sum), 32'(v_threshold), DATA_W));
        end
    end

endmodule
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron_array
// Description : Time-multiplexed array of leaky integrate-and-fire neurons
//               with event accumulation and a backpressured update sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int DATA_W      = 16,
    parameter int REFRAC_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] cfg_v_threshold,
    input  logic signed [DATA_W-1:0] cfg_v_reset,
    input  logic                     cfg_reset_mode,
    input  logic [3:0]               cfg_leak_shift,
    input  logic [REFRAC_W-1:0]      cfg_refrac,
    input  logic                     step_start,
    input  logic                     step_end,
    output logic                     busy,
    output logic                     done,
    lif_neuron_array_if.slave        bus
);

    localparam int              ID_W     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_NEURONS - 1);

    state_t                   r_state;
    logic [ID_W-1:0]          r_idx;
    logic                     r_in_ready;
    logic                     r_spike_valid;
    logic [ID_W-1:0]          r_spike_id;
    logic                     r_busy;
    logic                     r_done;

    logic signed [DATA_W-1:0] r_vth;
    logic signed [DATA_W-1:0] r_vreset;
    logic                     r_mode;
    logic [3:0]               r_shift;
    logic [REFRAC_W-1:0]      r_refrac;

    logic signed [DATA_W-1:0] r_v [NUM_NEURONS];
    logic signed [DATA_W-1:0] r_a [NUM_NEURONS];
    logic [REFRAC_W-1:0]      r_r [NUM_NEURONS];

    logic                     w_accept;
    logic                     w_in_range;
    logic                     w_can_eval;
    logic signed [DATA_W-1:0] w_v_next;
    logic [REFRAC_W-1:0]      w_r_next;
    logic                     w_fire;

    assign w_accept   = (r_state == ST_ACCUM) && bus.in_valid && r_in_ready;
    assign w_in_range = 32'(bus.in_id) < NUM_NEURONS;
    // The sweep only moves when the spike slot is empty or being drained this cycle.
    assign w_can_eval = !r_spike_valid || bus.spike_ready;

    assign bus.in_ready    = r_in_ready;
    assign bus.spike_valid = r_spike_valid;
    assign bus.spike_id    = r_spike_id;
    assign busy            = r_busy;
    assign done            = r_done;

    lif_neuron_update #(
        .DATA_W   (DATA_W),
        .REFRAC_W (REFRAC_W)
    ) u_update (
        .v           (r_v[r_idx]),
        .a           (r_a[r_idx]),
        .r           (r_r[r_idx]),
        .v_threshold (r_vth),
        .v_reset     (r_vreset),
        .reset_mode  (r_mode),
        .leak_shift  (r_shift),
        .refrac      (r_refrac),
        .v_next      (w_v_next),
        .r_next      (w_r_next),
        .fire        (w_fire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_in_ready    <= 1'b0;
            r_spike_valid <= 1'b0;
            r_spike_id    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_vth         <= '0;
            r_vreset      <= '0;
            r_mode        <= RESET_SUBTRACT;
            r_shift       <= '0;
            r_refrac      <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_v[i] <= '0;
                r_a[i] <= '0;
                r_r[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (r_spike_valid && bus.spike_ready)
                r_spike_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (step_start) begin
                        r_vth      <= cfg_v_threshold;
                        r_vreset   <= cfg_v_reset;
                        r_mode     <= cfg_reset_mode;
                        r_shift    <= cfg_leak_shift;
                        r_refrac   <= cfg_refrac;
                        for (int i = 0; i < NUM_NEURONS; i++)
                            r_a[i] <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept && w_in_range)
                        r_a[bus.in_id] <= DATA_W'(sat_add(32'(r_a[bus.in_id]),
                                                          32'(bus.in_weight), DATA_W));
                    if (step_end) begin
                        r_in_ready <= 1'b0;
                        r_idx      <= '0;
                        r_state    <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (w_can_eval) begin
                        r_v[r_idx] <= w_v_next;
                        r_r[r_idx] <= w_r_next;
                        if (w_fire) begin
                            r_spike_valid <= 1'b1;
                            r_spike_id    <= r_idx;
                        end
                        if (r_idx == LAST_IDX)
                            r_state <= ST_FINISH;
                        else
                            r_idx <= r_idx + 1'b1;
                    end
                end
                ST_FINISH: begin
                    if (w_can_eval) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
